logic_pod_serialization: RTL

- Readout-side counterpart of the logic pod capture packer.
- Pops 128-bit packed words from the capture CDC FIFO (read domain) and re-emits the 17-bit compressor blocks {format, data[15:0]}, oldest first, on a valid/ready stream.
- The stream feeds the decompressor/readout path.
- Honours the per-word block-count header, including short words produced by a flush.

---
 rtl/logic_pod_pkg.sv | 35 +++
 rtl/logic_pod_word_unpacker.sv | 63 ++++++
 rtl/logic_pod_serialization.sv | 101 ++++++++++
 3 files changed

// File: rtl/logic_pod_pkg.sv
// Shared layout definitions for the logic pod capture packer and its readout serializer.
package logic_pod_pkg;

  localparam int BLOCK_W         = 17;
  localparam int BLOCKS_PER_WORD = 7;
  localparam int WORD_W          = 128;
  localparam int PAYLOAD_W       = BLOCK_W * BLOCKS_PER_WORD;

  localparam int COUNT_HI = 127;
  localparam int COUNT_LO = 120;
  localparam int RSVD_BIT = 119;

  typedef struct packed {
    logic        format;
    logic [15:0] data;
  } logic_pod_block_t;

  typedef struct packed {
    logic [7:0]           count;
    logic                 rsvd;
    logic [PAYLOAD_W-1:0] blocks;
  } logic_pod_word_t;

  // A header is usable when the count fits in one word and the reserved bit is clear.
  function automatic logic header_ok(input logic [WORD_W-1:0] w);
    return (w[COUNT_HI:COUNT_LO] <= 8'd7) && !w[RSVD_BIT];
  endfunction

  // Pushes the n valid blocks to the top of the payload so the oldest sits in the top 17 bits.
  function automatic logic [PAYLOAD_W-1:0] align_blocks(input logic [PAYLOAD_W-1:0] blocks,
                                                        input logic [2:0]           n);
    return blocks << (BLOCK_W * (BLOCKS_PER_WORD - int'(n)));
  endfunction

endpackage

// File: rtl/logic_pod_word_unpacker.sv
// Streams the blocks of one loaded word oldest-first and flags the end of short words.
module logic_pod_word_unpacker
  import logic_pod_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [2:0]           loadCount_i,
  input  logic [PAYLOAD_W-1:0] loadBlocks_i,
  input  logic                 outReady_i,
  output logic                 outValid_o,
  output logic_pod_block_t     outBlock_o,
  output logic                 outFlush_o,
  output logic                 canLoad_o,
  output logic                 empty_o
);

  logic [PAYLOAD_W-1:0] shiftReg_q, shiftReg_d;
  logic [2:0]           remain_q, remain_d;
  logic                 short_q, short_d;
  logic                 accept;
  logic                 lastAccept;

  // Output view and handshake: the current block is always the top of the shift register.
  always_comb begin
    empty_o    = (remain_q == 3'd0);
    outValid_o = !empty_o;
    outBlock_o = logic_pod_block_t'(shiftReg_q[PAYLOAD_W-1 -: BLOCK_W]);
    accept     = outValid_o && outReady_i;
    lastAccept = accept && (remain_q == 3'd1);
    canLoad_o  = empty_o || lastAccept;
    outFlush_o = (lastAccept && short_q) || (load_i && (loadCount_i == 3'd0));
  end

  // Next state: a load replaces the word outright, otherwise each accepted beat shifts one block out.
  always_comb begin
    shiftReg_d = shiftReg_q;
    remain_d   = remain_q;
    short_d    = short_q;
    if (load_i) begin
      shiftReg_d = align_blocks(loadBlocks_i, loadCount_i);
      remain_d   = loadCount_i;
      short_d    = (loadCount_i != 3'd7);
    end else if (accept) begin
      shiftReg_d = shiftReg_q << BLOCK_W;
      remain_d   = remain_q - 3'd1;
    end
  end

  // Word state register; reset empties it so nothing stale can be emitted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shiftReg_q <= '0;
      remain_q   <= 3'd0;
      short_q    <= 1'b0;
    end else begin
      shiftReg_q <= shiftReg_d;
      remain_q   <= remain_d;
      short_q    <= short_d;
    end
  end

endmodule

// File: rtl/logic_pod_serialization.sv
// Pops packed capture words from the CDC FIFO and re-emits their 17-bit blocks as a stream.
module logic_pod_serialization
  import logic_pod_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  output logic                 fifo_rd,
  input  logic [WORD_W-1:0]    fifo_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_format,
  output logic [15:0]          out_data,
  output logic                 out_flush,
  output logic                 err_bad_count,
  output logic [ERR_CNT_W-1:0] err_count
);

  logic_pod_word_t      holdWord_q, holdWord_d;
  logic                 holdValid_q, holdValid_d;
  logic                 inFlight_q, inFlight_d;
  logic [ERR_CNT_W-1:0] errCount_q, errCount_d;

  logic             holdGood;
  logic             holdIsEmptyFlush;
  logic             holdConsume;
  logic             unpackLoad;
  logic             badDrop;
  logic             canLoad;
  logic             unpackEmpty;
  logic_pod_block_t outBlock;

  // Decide what happens to the held word. An empty flush word only loads into an idle unpacker so its
  // flush pulse can never merge with the end-of-word pulse of the word ahead of it.
  always_comb begin
    holdGood         = header_ok(holdWord_q);
    holdIsEmptyFlush = holdGood && (holdWord_q.count == 8'd0);
    holdConsume      = holdValid_q && (holdIsEmptyFlush ? unpackEmpty : canLoad);
    unpackLoad       = holdConsume && holdGood;
    badDrop          = holdConsume && !holdGood;
    fifo_rd          = !rst && !fifo_empty && !inFlight_q && (!holdValid_q || holdConsume);
    err_bad_count    = badDrop;
    err_count        = errCount_q;
  end

  // Prefetch bookkeeping and the saturating dropped-word counter.
  always_comb begin
    holdWord_d  = holdWord_q;
    holdValid_d = holdValid_q;
    inFlight_d  = fifo_rd;
    errCount_d  = errCount_q;
    if (holdConsume) begin
      holdValid_d = 1'b0;
    end
    if (inFlight_q) begin
      holdWord_d  = logic_pod_word_t'(fifo_rdata);
      holdValid_d = 1'b1;
    end
    if (badDrop && (errCount_q != '1)) begin
      errCount_d = errCount_q + 1'b1;
    end
  end

  // Prefetch and error registers; reset drops the held word and forgets any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdWord_q  <= '0;
      holdValid_q <= 1'b0;
      inFlight_q  <= 1'b0;
      errCount_q  <= '0;
    end else begin
      holdWord_q  <= holdWord_d;
      holdValid_q <= holdValid_d;
      inFlight_q  <= inFlight_d;
      errCount_q  <= errCount_d;
    end
  end

  logic_pod_word_unpacker u_unpacker (
    .clk          (clk),
    .rst          (rst),
    .load_i       (unpackLoad),
    .loadCount_i  (holdWord_q.count[2:0]),
    .loadBlocks_i (holdWord_q.blocks),
    .outReady_i   (out_ready),
    .outValid_o   (out_valid),
    .outBlock_o   (outBlock),
    .outFlush_o   (out_flush),
    .canLoad_o    (canLoad),
    .empty_o      (unpackEmpty)
  );

  // Split the current block onto the stream fields.
  always_comb begin
    out_format = outBlock.format;
    out_data   = outBlock.data;
  end

endmodule
